// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares the framebuffer write port between PPU pixels, a clear engine and OSD writes.
module fb_write_arbiter #(
    parameter int FB_W       = 256,
    parameter int FB_H       = 240,
    parameter int COLOR_W    = 6,
    parameter int CLEAR_SYNC = 1
) (
    input  logic               I_CLK,
    input  logic               I_RESET_N,
    input  logic               I_PPU_CE,
    input  logic [COLOR_W-1:0] I_PPU_COLOR,
    input  logic [8:0]         I_PPU_HCNT,
    input  logic [8:0]         I_PPU_VCNT,
    input  logic               I_OSD_VALID,
    output logic               O_OSD_READY,
    input  logic [15:0]        I_OSD_ADDR,
    input  logic [COLOR_W-1:0] I_OSD_COLOR,
    input  logic               I_CLEAR_REQ,
    input  logic [COLOR_W-1:0] I_CLEAR_COLOR,
    output logic               O_CLEAR_BUSY,
    output logic [15:0]        O_FB_ADDR,
    output logic [COLOR_W-1:0] O_FB_DATA,
    output logic               O_FB_WREN
);
    localparam logic [8:0] W9     = 9'(FB_W);
    localparam logic [8:0] H9     = 9'(FB_H);
    localparam logic [7:0] X_LAST = 8'(FB_W - 1);
    localparam logic [7:0] Y_LAST = 8'(FB_H - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CLEAR} state_t;

    state_t             state;
    logic [7:0]         cx, cy;
    logic [COLOR_W-1:0] clr_color;
    logic               ppu_hit, osd_in_range, osd_write, clr_last, x_wrap;

    assign ppu_hit      = I_PPU_CE && I_PPU_HCNT < W9 && I_PPU_VCNT < H9;
    assign O_OSD_READY  = !ppu_hit && state != CLEAR;
    assign osd_in_range = {1'b0, I_OSD_ADDR[7:0]} < W9 && {1'b0, I_OSD_ADDR[15:8]} < H9;
    assign osd_write    = I_OSD_VALID && O_OSD_READY && osd_in_range;
    assign x_wrap       = cx == X_LAST;
    assign clr_last     = x_wrap && cy == Y_LAST;

    always_ff @(posedge I_CLK) begin
        if (!I_RESET_N) begin
            state        <= IDLE;
            cx           <= '0;
            cy           <= '0;
            clr_color    <= '0;
            O_CLEAR_BUSY <= 1'b0;
            O_FB_WREN    <= 1'b0;
            O_FB_ADDR    <= '0;
            O_FB_DATA    <= '0;
        end else begin
            O_FB_WREN <= ppu_hit || state == CLEAR || osd_write;
            if (ppu_hit) begin
                O_FB_ADDR <= {I_PPU_VCNT[7:0], I_PPU_HCNT[7:0]};
                O_FB_DATA <= I_PPU_COLOR;
            end else if (state == CLEAR) begin
                O_FB_ADDR <= {cy, cx};
                O_FB_DATA <= clr_color;
            end else if (osd_write) begin
                O_FB_ADDR <= I_OSD_ADDR;
                O_FB_DATA <= I_OSD_COLOR;
            end
            if (state == IDLE && I_CLEAR_REQ) begin
                clr_color    <= I_CLEAR_COLOR;
                O_CLEAR_BUSY <= 1'b1;
                state        <= CLEAR_SYNC != 0 ? ARMED : CLEAR;
            end else if (state == ARMED && I_PPU_VCNT == H9) begin
                state <= CLEAR;
            end else if (state == CLEAR && !ppu_hit) begin
                // counters only advance on cycles the clear actually owns the port
                cx <= x_wrap ? '0 : cx + 8'd1;
                cy <= clr_last ? '0 : x_wrap ? cy + 8'd1 : cy;
                if (clr_last) begin
                    state        <= IDLE;
                    O_CLEAR_BUSY <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: scoreboard bench over three arbiter configurations (full/async, full/sync, small/async).
module tb_fb_write_arbiter;
    typedef struct packed {
        logic        wren;
        logic [15:0] addr;
        logic [5:0]  data;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ppu_ce;
    logic [5:0]  ppu_color;
    logic [8:0]  hcnt, vcnt;
    logic        osd_valid;
    logic [15:0] osd_addr;
    logic [5:0]  osd_color;
    logic        clr_req;
    logic [5:0]  clr_color;

    logic        ready [3];
    logic        busy  [3];
    logic [15:0] addr  [3];
    logic [5:0]  data  [3];
    logic        wren  [3];

    int   checks = 0;
    int   failures = 0;
    int   sel = 0;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    fb_write_arbiter #(.FB_W(256), .FB_H(240), .COLOR_W(6), .CLEAR_SYNC(0)) d0 (
        .I_CLK(clk), .I_RESET_N(rst_n), .I_PPU_CE(ppu_ce), .I_PPU_COLOR(ppu_color),
        .I_PPU_HCNT(hcnt), .I_PPU_VCNT(vcnt), .I_OSD_VALID(osd_valid), .O_OSD_READY(ready[0]),
        .I_OSD_ADDR(osd_addr), .I_OSD_COLOR(osd_color), .I_CLEAR_REQ(clr_req),
        .I_CLEAR_COLOR(clr_color), .O_CLEAR_BUSY(busy[0]), .O_FB_ADDR(addr[0]),
        .O_FB_DATA(data[0]), .O_FB_WREN(wren[0]));

    fb_write_arbiter #(.FB_W(256), .FB_H(240), .COLOR_W(6), .CLEAR_SYNC(1)) d1 (
        .I_CLK(clk), .I_RESET_N(rst_n), .I_PPU_CE(ppu_ce), .I_PPU_COLOR(ppu_color),
        .I_PPU_HCNT(hcnt), .I_PPU_VCNT(vcnt), .I_OSD_VALID(osd_valid), .O_OSD_READY(ready[1]),
        .I_OSD_ADDR(osd_addr), .I_OSD_COLOR(osd_color), .I_CLEAR_REQ(clr_req),
        .I_CLEAR_COLOR(clr_color), .O_CLEAR_BUSY(busy[1]), .O_FB_ADDR(addr[1]),
        .O_FB_DATA(data[1]), .O_FB_WREN(wren[1]));

    fb_write_arbiter #(.FB_W(16), .FB_H(4), .COLOR_W(6), .CLEAR_SYNC(0)) ds (
        .I_CLK(clk), .I_RESET_N(rst_n), .I_PPU_CE(ppu_ce), .I_PPU_COLOR(ppu_color),
        .I_PPU_HCNT(hcnt), .I_PPU_VCNT(vcnt), .I_OSD_VALID(osd_valid), .O_OSD_READY(ready[2]),
        .I_OSD_ADDR(osd_addr), .I_OSD_COLOR(osd_color), .I_CLEAR_REQ(clr_req),
        .I_CLEAR_COLOR(clr_color), .O_CLEAR_BUSY(busy[2]), .O_FB_ADDR(addr[2]),
        .O_FB_DATA(data[2]), .O_FB_WREN(wren[2]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ppu_ce = 0; ppu_color = 0; hcnt = 0; vcnt = 0;
        osd_valid = 0; osd_addr = 0; osd_color = 0;
        clr_req = 0; clr_color = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        ppu_ce = 1; hcnt = 9'h10; vcnt = 9'h2; ppu_color = 6'h2A;
        clr_req = 1; clr_color = 6'h15;
        osd_valid = 1; osd_addr = 16'h0101; osd_color = 6'h11;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({wren[i], addr[i], data[i], busy[i]} !== 24'h0) begin
                failures++;
                $display("FAIL reset[%0d]: got wren=%b addr=%h data=%h busy=%b, want all zero",
                         i, wren[i], addr[i], data[i], busy[i]);
            end
        end
        idle_inputs();
        rst_n = 1;
    endtask

    task automatic test_full_clear();
        sel = 0;
        do_reset();
        clr_req = 1; clr_color = 6'h0F;
        q.push_back('{1'b0, 16'h0000, 6'h00, 1'b1});
        for (int k = 0; k < 256 * 240; k++)
            q.push_back('{1'b1, 16'(((k / 256) << 8) | (k % 256)), 6'h0F, k != 256 * 240 - 1});
        q.push_back('{1'b0, 16'hEFFF, 6'h0F, 1'b0});
        step();
        clr_req = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({wren[sel], addr[sel], data[sel], busy[sel]} !== e) begin
                failures++;
                $display("FAIL full_clear: got wren=%b addr=%h data=%h busy=%b, want wren=%b addr=%h data=%h busy=%b",
                         wren[sel], addr[sel], data[sel], busy[sel], e.wren, e.addr, e.data, e.busy);
            end
            if (q.size() > 0) step();
        end
    endtask

    task automatic test_ppu();
        logic [8:0]  th [7] = '{9'h010, 9'h100, 9'h010, 9'd255, 9'd5, 9'd0, 9'h1FF};
        logic [8:0]  tv [7] = '{9'h020, 9'h020, 9'd240, 9'd239, 9'd5, 9'd0, 9'h1FF};
        logic        tce[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [5:0]  tc [7] = '{6'h16, 6'h01, 6'h02, 6'h3F, 6'h05, 6'h00, 6'h07};
        exp_t        te [7] = '{'{1'b1, 16'h2010, 6'h16, 1'b0}, '{1'b0, 16'h2010, 6'h16, 1'b0},
                                '{1'b0, 16'h2010, 6'h16, 1'b0}, '{1'b1, 16'hEFFF, 6'h3F, 1'b0},
                                '{1'b0, 16'hEFFF, 6'h3F, 1'b0}, '{1'b1, 16'h0000, 6'h00, 1'b0},
                                '{1'b0, 16'h0000, 6'h00, 1'b0}};
        sel = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            ppu_ce = tce[i]; hcnt = th[i]; vcnt = tv[i]; ppu_color = tc[i];
            q.push_back(te[i]);
            step();
            e = q.pop_front();
            checks++;
            if ({wren[sel], addr[sel], data[sel], busy[sel]} !== e) begin
                failures++;
                $display("FAIL ppu[%0d]: got wren=%b addr=%h data=%h, want wren=%b addr=%h data=%h",
                         i, wren[sel], addr[sel], data[sel], e.wren, e.addr, e.data);
            end
        end
        idle_inputs();
    endtask

    task automatic test_clear_interleave();
        int k = 0;
        int ncyc = 0;
        logic [15:0] la = 16'h0;
        logic [5:0]  ld = 6'h0;
        sel = 2;
        do_reset();
        clr_req = 1; clr_color = 6'h2A;
        q.push_back('{1'b0, 16'h0000, 6'h00, 1'b1});
        step();
        e = q.pop_front();
        checks++;
        if ({wren[sel], addr[sel], data[sel], busy[sel]} !== e) begin
            failures++;
            $display("FAIL interleave_accept: got wren=%b busy=%b, want wren=0 busy=1", wren[sel], busy[sel]);
        end
        clr_req = 0;
        for (int i = 0; i < 300 && k < 64; i++) begin
            ppu_ce = i[0]; hcnt = 9'(i & 15); vcnt = 9'((i >> 4) & 3); ppu_color = 6'(i);
            if (i[0]) begin
                la = {7'h0, vcnt, 8'h0} | {8'h0, hcnt[7:0]};
                ld = 6'(i);
                q.push_back('{1'b1, la, ld, 1'b1});
            end else begin
                la = 16'(((k / 16) << 8) | (k % 16));
                ld = 6'h2A;
                k++;
                q.push_back('{1'b1, la, ld, k < 64});
            end
            step();
            ncyc = i + 1;
            e = q.pop_front();
            checks++;
            if ({wren[sel], addr[sel], data[sel], busy[sel]} !== e) begin
                failures++;
                $display("FAIL interleave[%0d]: got wren=%b addr=%h data=%h busy=%b, want wren=%b addr=%h data=%h busy=%b",
                         i, wren[sel], addr[sel], data[sel], busy[sel], e.wren, e.addr, e.data, e.busy);
            end
        end
        checks++;
        if (ncyc !== 127) begin
            failures++;
            $display("FAIL interleave_cycles: got %0d cycles, want 127", ncyc);
        end
        idle_inputs();
        q.push_back('{1'b0, la, ld, 1'b0});
        step();
        e = q.pop_front();
        checks++;
        if ({wren[sel], addr[sel], data[sel], busy[sel]} !== e) begin
            failures++;
            $display("FAIL interleave_done: got wren=%b addr=%h busy=%b, want wren=0 addr=%h busy=0",
                     wren[sel], addr[sel], busy[sel], e.addr);
        end
    endtask

    task automatic test_osd();
        sel = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            logic want_ready;
            idle_inputs();
            osd_valid = 1; osd_addr = 16'h1234; osd_color = 6'h30;
            case (i)
                0: begin ppu_ce = 1; hcnt = 9'd1; vcnt = 9'd1; ppu_color = 6'h05;
                         want_ready = 0; q.push_back('{1'b1, 16'h0101, 6'h05, 1'b0}); end
                1: begin want_ready = 1; q.push_back('{1'b1, 16'h1234, 6'h30, 1'b0}); end
                2: begin osd_addr = 16'hF500; osd_color = 6'h11;
                         want_ready = 1; q.push_back('{1'b0, 16'h1234, 6'h30, 1'b0}); end
                3: begin osd_valid = 0; want_ready = 1; q.push_back('{1'b0, 16'h1234, 6'h30, 1'b0}); end
                4: begin osd_addr = 16'h0203; osd_color = 6'h21; clr_req = 1; clr_color = 6'h07;
                         want_ready = 1; q.push_back('{1'b1, 16'h0203, 6'h21, 1'b1}); end
                default: begin osd_addr = 16'h0405; want_ready = 0;
                         q.push_back('{1'b1, 16'h0000, 6'h07, 1'b1}); end
            endcase
            #1;
            checks++;
            if (ready[sel] !== want_ready) begin
                failures++;
                $display("FAIL osd_ready[%0d]: got %b, want %b", i, ready[sel], want_ready);
            end
            step();
            e = q.pop_front();
            checks++;
            if ({wren[sel], addr[sel], data[sel], busy[sel]} !== e) begin
                failures++;
                $display("FAIL osd[%0d]: got wren=%b addr=%h data=%h busy=%b, want wren=%b addr=%h data=%h busy=%b",
                         i, wren[sel], addr[sel], data[sel], busy[sel], e.wren, e.addr, e.data, e.busy);
            end
        end
        idle_inputs();
    endtask

    task automatic test_sync_clear();
        sel = 1;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            idle_inputs();
            vcnt = 9'd100;
            if (i == 0) begin clr_req = 1; clr_color = 6'h12; q.push_back('{1'b0, 16'h0, 6'h0, 1'b1}); end
            else if (i == 1) begin clr_req = 1; clr_color = 6'h33; q.push_back('{1'b0, 16'h0, 6'h0, 1'b1}); end
            else if (i == 2) begin osd_valid = 1; osd_addr = 16'h0505; osd_color = 6'h09;
                                   q.push_back('{1'b1, 16'h0505, 6'h09, 1'b1}); end
            else if (i < 7) q.push_back('{1'b0, 16'h0505, 6'h09, 1'b1});
            else if (i == 7) begin vcnt = 9'd240; q.push_back('{1'b0, 16'h0505, 6'h09, 1'b1}); end
            else if (i < 11) begin vcnt = 9'd240; osd_valid = 1; osd_addr = 16'h0707;
                                   q.push_back('{1'b1, 16'(i - 8), 6'h12, 1'b1}); end
            else if (i == 11) begin rst_n = 0; vcnt = 9'd240; q.push_back('{1'b0, 16'h0, 6'h0, 1'b0}); end
            else begin rst_n = 1; vcnt = 9'd240; q.push_back('{1'b0, 16'h0, 6'h0, 1'b0}); end
            step();
            e = q.pop_front();
            checks++;
            if ({wren[sel], addr[sel], data[sel], busy[sel]} !== e) begin
                failures++;
                $display("FAIL sync_clear[%0d]: got wren=%b addr=%h data=%h busy=%b, want wren=%b addr=%h data=%h busy=%b",
                         i, wren[sel], addr[sel], data[sel], busy[sel], e.wren, e.addr, e.data, e.busy);
            end
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_ppu();
        test_osd();
        test_sync_clear();
        test_clear_interleave();
        test_full_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Sequences the single write port of the 256x240 framebuffer between three writers.
- Writers in priority order: PPU pixel stream (fixed priority, never stalled), a hardware clear engine, and an OSD/menu writer using a valid/ready handshake.
- Sits between the PPU/OSD logic and the framebuffer port-A inputs (address, data, write enable) in the I_CLK domain.
- Output is registered; framebuffer address format is {y[7:0], x[7:0]}.

Parameters:
- FB_W, 256, visible framebuffer width in pixels.
- FB_H, 240, visible framebuffer height in lines.
- COLOR_W, 6, NES palette index width.
- CLEAR_SYNC, 1. When 1, a clear waits for PPU vblank (I_PPU_VCNT == FB_H) before starting. When 0, it starts on the next cycle.

Ports:
- I_CLK  in  1  system clock; all logic on the rising edge.
- I_RESET_N  in  1  synchronous, active-low reset.
- I_PPU_CE  in  1  PPU pixel strobe.
- I_PPU_COLOR  in  COLOR_W  PPU pixel colour.
- I_PPU_HCNT  in  9  PPU horizontal counter.
- I_PPU_VCNT  in  9  PPU vertical counter.
- I_OSD_VALID  in  1  OSD write request.
- O_OSD_READY  out  1  OSD request accepted this cycle (combinational).
- I_OSD_ADDR  in  16  OSD target {y, x}.
- I_OSD_COLOR  in  COLOR_W  OSD pixel colour.
- I_CLEAR_REQ  in  1  start clear (sampled level; pulse expected).
- I_CLEAR_COLOR  in  COLOR_W  fill colour, latched on accept.
- O_CLEAR_BUSY  out  1  high from accept until the last clear write is issued.
- O_FB_ADDR  out  16  framebuffer write address.
- O_FB_DATA  out  COLOR_W  framebuffer write data.
- O_FB_WREN  out  1  framebuffer write enable.

Behaviour:
- Reset (I_RESET_N=0 at an edge):
  - O_FB_WREN=0, O_FB_ADDR=0, O_FB_DATA=0, O_CLEAR_BUSY=0.
  - FSM goes to IDLE; clear counters go to 0.
  - Reset mid-clear abandons the clear with no further writes.
- PPU hit: ppu_hit = I_PPU_CE && I_PPU_HCNT < FB_W && I_PPU_VCNT < FB_H.
  - A hit always wins.
  - Next cycle: O_FB_WREN=1, O_FB_ADDR={VCNT[7:0], HCNT[7:0]}, O_FB_DATA=I_PPU_COLOR. Latency is 1 cycle.
- FSM states:
  - IDLE: I_CLEAR_REQ → latch colour, O_CLEAR_BUSY=1. Go to ARMED if CLEAR_SYNC=1, else CLEAR.
  - ARMED: wait until I_PPU_VCNT == FB_H, then go to CLEAR. OSD writes are still served in ARMED.
  - CLEAR:
    - Counters cx (0..FB_W-1) and cy (0..FB_H-1) advance one pixel per cycle in which ppu_hit=0; each advance issues a write of {cy, cx} with the latched colour.
    - cx wraps to 0 and increments cy.
    - After the write of (FB_W-1, FB_H-1): counters reset, O_CLEAR_BUSY drops on the same edge as that write's O_FB_WREN, FSM goes to IDLE.
    - A cycle with ppu_hit=1 stalls the counters; no clear pixel is skipped or duplicated.
- I_CLEAR_REQ in ARMED or CLEAR is ignored; the colour is not re-latched.
- OSD handshake:
  - O_OSD_READY = !ppu_hit && state != CLEAR.
  - A transfer occurs when I_OSD_VALID && O_OSD_READY.
  - In range (x < FB_W and y < FB_H): issue the write next cycle.
  - Out of range: transfer is accepted (ready still 1) but the write is suppressed, O_FB_WREN=0.
  - The OSD may hold I_OSD_VALID indefinitely. It is starved during CLEAR and on PPU-hit cycles, which is intended.
- Idle cycles: O_FB_WREN=0; O_FB_ADDR/O_FB_DATA hold their last values.
- Simultaneous events:
  - ppu_hit + OSD valid + clear in the same cycle: only the PPU writes; the clear stalls; OSD ready=0.
  - I_CLEAR_REQ with a valid OSD transfer in IDLE: both accepted. The OSD write is issued and the clear begins per CLEAR_SYNC.
- Clear duration: exactly FB_W*FB_H writes (61440 by default), plus the PPU-stall cycles.

Test Plan:
- Reset, then CLEAR_SYNC=0, I_CLEAR_REQ pulse with colour 0x0F, no PPU/OSD activity:
  - Required: 61440 consecutive writes, addresses 0x0000..0x00FF, 0x0100..0xEFFF, all data 0x0F.
  - O_CLEAR_BUSY high for exactly those cycles.
- PPU CE every cycle, HCNT=0x10, VCNT=0x20, colour 0x16:
  - Required: next cycle O_FB_WREN=1, ADDR=0x2010, DATA=0x16.
  - Required: HCNT=256 or VCNT=240 → no write.
- Clear running with PPU hits on alternating cycles:
  - Required: clear addresses strictly sequential with no gaps or repeats.
  - Required: PPU writes interleave; the clear takes 2x cycles.
- OSD VALID held with ADDR=0x1234, COLOR=0x30 during a PPU hit, then PPU idle:
  - Required: READY=0 during the hit, then READY=1; one write to 0x1234 with data 0x30.
  - Required: OSD ADDR=0xF500 (y=245) → accepted, no WREN.
- CLEAR_SYNC=1, request while VCNT=100:
  - Required: O_CLEAR_BUSY=1 but no clear writes until VCNT=240; a second I_CLEAR_REQ during ARMED is ignored.
  - Required: I_RESET_N=0 mid-CLEAR → next cycle WREN=0, BUSY=0, FSM in IDLE.
